mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Clocking SHALL be one clock, CLK; reset RST SHALL be synchronous and active-high.
REQ-002 Ports SHALL be:
- CLK  in  1  clock
- RST  in  1  sync active-high reset
- ex_valid  in  1  EX/MEM instruction valid
- opcode  in  6  instruction opcode
- alu_in  in  32  ALU result / effective address
- store_data  in  32  rt value for stores
- halt_in  in  1  instruction is HALT
- flush  in  1  squash current IDLE-cycle instruction
- dhit  in  1  cache transaction complete
- dload  in  32  cache read data
- inv_valid  in  1  coherence invalidate strobe
- inv_addr  in  32  invalidated address
- dREN  out  1  cache read request
- dWEN  out  1  cache write request
- daddr  out  32  word-aligned request address
- dstore  out  32  store data
- mem_stall  out  1  freeze upstream stages
- memory_en  out  1  enable for downstream MEM/WB latch
- dloadi  out  32  captured load data
- alui  out  32  result to MEM/WB latch
- halt_out  out  1  sticky halt
- link_valid  out  1  LL reservation held

Function
REQ-003 Memory ops SHALL be LW=0x23, SW=0x2B, LL=0x30, SC=0x38; all other opcodes SHALL be non-memory.
REQ-004 The FSM SHALL have states IDLE, REQ, DONE, HALTED.
REQ-005 In IDLE with ex_valid=1, flush=0, halt_in=0, and a non-memory op (or failing SC): memory_en=1, mem_stall=0, alui=alu_in (failing SC: alui=0), no request; the state SHALL stay IDLE.
REQ-006 In IDLE with an accepted LW/LL/SW/passing SC: mem_stall=1, memory_en=0; the block SHALL register daddr={alu_in[31:2],2'b00} and dstore=store_data and go to REQ.
REQ-007 In REQ: dREN=1 for LW/LL, dWEN=1 for SW/SC, mem_stall=1, memory_en=0; on dhit=1 the block SHALL capture dload into dloadi for loads and go to DONE; otherwise it SHALL hold every request output.
REQ-008 In DONE: dREN=dWEN=0, mem_stall=0, memory_en=1; alui SHALL be the registered address for LW/LL/SW and 1 for SC; the state SHALL return to IDLE.
REQ-009 Minimum memory-op latency SHALL be 3 cycles (IDLE, REQ with dhit, DONE); each extra dhit=0 cycle SHALL add one cycle.
REQ-010 An LL completing in DONE SHALL set link_valid=1 and link address = daddr[31:2].
REQ-011 SC passes iff link_valid=1 and alu_in[31:2]=link[31:2] in the IDLE cycle; a passing SC SHALL clear link_valid on entering REQ.
REQ-012 inv_valid=1 with inv_addr[31:2]=link[31:2] SHALL clear link_valid next cycle.
REQ-013 An invalidate in the same cycle as an LL DONE, matching the new link address, SHALL leave link_valid=0 (invalidate wins).
REQ-014 An invalidate in the same IDLE cycle as an SC to the matching address SHALL make that SC fail.
REQ-015 flush=1 in IDLE SHALL suppress acceptance: memory_en=0, mem_stall=0, no request, no link change; flush SHALL be ignored in REQ, DONE, and HALTED (the cache transaction is committed).
REQ-016 halt_in=1 with ex_valid=1 in IDLE (flush=0) SHALL assert memory_en=1 for that cycle and enter HALTED.
REQ-017 HALTED SHALL hold halt_out=1, mem_stall=1, memory_en=0, and no requests until RST.
REQ-018 ex_valid=0 in IDLE SHALL give memory_en=0 and mem_stall=0.

Reset
REQ-019 RST=1 SHALL force state IDLE and set every output to 0 (including dloadi, alui, daddr, dstore, halt_out, link_valid) on the next edge, overriding any state, including mid-REQ.
REQ-020 After RST the block SHALL ignore any dhit belonging to an aborted request.

Verification
REQ-021 LW at alu_in=0x0000_1006, dhit high on the first REQ cycle, dload=0xDEADBEEF -> daddr=0x1004; dREN for 1 cycle; memory_en pulses in cycle 3; dloadi=0xDEADBEEF.
REQ-022 SW with dhit delayed 4 cycles -> dWEN held 4 cycles with daddr/dstore stable; mem_stall high for 5 cycles; memory_en in cycle 6.
REQ-023 LL 0x200, then SC 0x200 data 0x55 -> SC writes; alui=1; link_valid=0 afterwards.
REQ-024 LL 0x200, then inv_addr=0x203, then SC 0x200 -> no dWEN; alui=0; memory_en in the same cycle; no stall.
REQ-025 HALT following an ADD -> ADD passes with memory_en=1; then halt_out=1 and mem_stall=1 stick, and a later LW issues no dREN.
REQ-026 RST asserted in REQ cycle 2 of a LW -> all outputs 0 next cycle; a subsequent dhit=1 causes no capture; state is IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache access controller: issues cache requests, stalls upstream,
// tracks the LL/SC reservation and holds a sticky halt until reset.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   ex_valid, opcode      EX/MEM instruction valid and opcode
//   alu_in, store_data    effective address / ALU result, store data
//   halt_in, flush        HALT instruction, squash of the IDLE-cycle instruction
//   dhit, dload           cache completion and read data
//   inv_valid, inv_addr   coherence invalidate strobe and address
//   dREN, dWEN            cache read / write request
//   daddr, dstore         registered word address and store data
//   mem_stall, memory_en  upstream freeze, MEM/WB latch enable
//   dloadi, alui          captured load data, result to MEM/WB
//   halt_out, link_valid  sticky halt, LL reservation held

module mem_access_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_data,
    input  logic        halt_in,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dload,
    input  logic        inv_valid,
    input  logic [31:0] inv_addr,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        mem_stall,
    output logic        memory_en,
    output logic [31:0] dloadi,
    output logic [31:0] alui,
    output logic        halt_out,
    output logic        link_valid
);

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;
    localparam logic [5:0] OP_LL = 6'h30;
    localparam logic [5:0] OP_SC = 6'h38;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dstore_q, dstore_d;
    logic [31:0] dloadi_q, dloadi_d;
    logic        load_q, load_d;
    logic        ll_q, ll_d;
    logic        sc_q, sc_d;
    logic [29:0] link_q, link_d;
    logic        link_valid_q, link_valid_d;

    logic is_lw, is_sw, is_ll, is_sc;
    logic inv_hit_link, inv_hit_new;
    logic sc_pass;
    logic take, accept_halt, accept_mem;

    // Only the word part of an invalidate address matters.
    logic unused_inv_lsb;
    assign unused_inv_lsb = ^inv_addr[1:0];

    assign is_lw = (opcode == OP_LW);
    assign is_sw = (opcode == OP_SW);
    assign is_ll = (opcode == OP_LL);
    assign is_sc = (opcode == OP_SC);

    assign inv_hit_link = inv_valid && (inv_addr[31:2] == link_q);
    assign inv_hit_new  = inv_valid && (inv_addr[31:2] == daddr_q[31:2]);

    // A same-cycle invalidate of the reserved line kills the SC.
    assign sc_pass = is_sc && link_valid_q
                     && (alu_in[31:2] == link_q) && !inv_hit_link;

    assign take        = (state_q == S_IDLE) && ex_valid && !flush;
    assign accept_halt = take && halt_in;
    assign accept_mem  = take && !halt_in
                         && (is_lw || is_sw || is_ll || sc_pass);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_halt) begin
                    state_d = S_HALTED;
                end else if (accept_mem) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dhit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:   state_d = S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request / reservation datapath
    always_comb begin
        daddr_d      = daddr_q;
        dstore_d     = dstore_q;
        dloadi_d     = dloadi_q;
        load_d       = load_q;
        ll_d         = ll_q;
        sc_d         = sc_q;
        link_d       = link_q;
        link_valid_d = link_valid_q;

        if (accept_mem) begin
            daddr_d  = {alu_in[31:2], 2'b00};
            dstore_d = store_data;
            load_d   = is_lw || is_ll;
            ll_d     = is_ll;
            sc_d     = is_sc;
        end

        if ((state_q == S_REQ) && dhit && load_q) begin
            dloadi_d = dload;
        end

        if (inv_hit_link) begin
            link_valid_d = 1'b0;
        end

        // A passing SC consumes the reservation.
        if (accept_mem && is_sc) begin
            link_valid_d = 1'b0;
        end

        // New reservation; an invalidate of the same line wins.
        if ((state_q == S_DONE) && ll_q) begin
            link_d       = daddr_q[31:2];
            link_valid_d = !inv_hit_new;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            daddr_q      <= '0;
            dstore_q     <= '0;
            dloadi_q     <= '0;
            load_q       <= 1'b0;
            ll_q         <= 1'b0;
            sc_q         <= 1'b0;
            link_q       <= '0;
            link_valid_q <= 1'b0;
        end else begin
            daddr_q      <= daddr_d;
            dstore_q     <= dstore_d;
            dloadi_q     <= dloadi_d;
            load_q       <= load_d;
            ll_q         <= ll_d;
            sc_q         <= sc_d;
            link_q       <= link_d;
            link_valid_q <= link_valid_d;
        end
    end

    // Output logic
    always_comb begin
        dREN      = 1'b0;
        dWEN      = 1'b0;
        mem_stall = 1'b0;
        memory_en = 1'b0;
        alui      = '0;
        halt_out  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    if (accept_mem) begin
                        mem_stall = 1'b1;
                    end else begin
                        memory_en = 1'b1;
                        // Non-halt SC reaching here has failed.
                        alui = (is_sc && !halt_in) ? 32'd0 : alu_in;
                    end
                end
            end
            S_REQ: begin
                mem_stall = 1'b1;
                dREN      = load_q;
                dWEN      = !load_q;
            end
            S_DONE: begin
                memory_en = 1'b1;
                alui      = sc_q ? 32'd1 : daddr_q;
            end
            S_HALTED: begin
                mem_stall = 1'b1;
                halt_out  = 1'b1;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

    assign daddr      = daddr_q;
    assign dstore     = dstore_q;
    assign dloadi     = dloadi_q;
    assign link_valid = link_valid_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl: a per-cycle vector table
// followed by hand-written multi-cycle sequences.

module tb_mem_access_ctrl;

    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] LL  = 6'h30;
    localparam logic [5:0] SC  = 6'h38;
    localparam logic [5:0] ADD = 6'h00;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ex_valid = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] alu_in = '0;
    logic [31:0] store_data = '0;
    logic        halt_in = 1'b0;
    logic        flush = 1'b0;
    logic        dhit = 1'b0;
    logic [31:0] dload = '0;
    logic        inv_valid = 1'b0;
    logic [31:0] inv_addr = '0;
    logic        dREN, dWEN, mem_stall, memory_en, halt_out, link_valid;
    logic [31:0] daddr, dstore, dloadi, alui;

    mem_access_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .ex_valid   (ex_valid),
        .opcode     (opcode),
        .alu_in     (alu_in),
        .store_data (store_data),
        .halt_in    (halt_in),
        .flush      (flush),
        .dhit       (dhit),
        .dload      (dload),
        .inv_valid  (inv_valid),
        .inv_addr   (inv_addr),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .mem_stall  (mem_stall),
        .memory_en  (memory_en),
        .dloadi     (dloadi),
        .alui       (alui),
        .halt_out   (halt_out),
        .link_valid (link_valid)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst, ex, h, f, dh, iv;
        logic [5:0]  op;
        logic [31:0] alu, sd, dl, ia;
        logic        ren, wen, stall, men, hlt, lv;
        logic [31:0] daddr, dstore, dloadi, alui;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(
        input logic rst, input logic ex, input logic [5:0] op,
        input logic [31:0] alu, input logic [31:0] sd,
        input logic h, input logic f, input logic dh,
        input logic [31:0] dl, input logic iv, input logic [31:0] ia,
        input logic ren, input logic wen,
        input logic [31:0] eaddr, input logic [31:0] estore,
        input logic stall, input logic men,
        input logic [31:0] eload, input logic [31:0] ealui,
        input logic hlt, input logic lv);
        vec_t v;
        v.rst = rst; v.ex = ex; v.op = op; v.alu = alu; v.sd = sd;
        v.h = h; v.f = f; v.dh = dh; v.dl = dl; v.iv = iv; v.ia = ia;
        v.ren = ren; v.wen = wen; v.daddr = eaddr; v.dstore = estore;
        v.stall = stall; v.men = men; v.dloadi = eload; v.alui = ealui;
        v.hlt = hlt; v.lv = lv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 ns later.
    task automatic drive(
        input logic rst, input logic ex, input logic [5:0] op,
        input logic [31:0] alu, input logic [31:0] sd,
        input logic h, input logic f, input logic dh,
        input logic [31:0] dl, input logic iv, input logic [31:0] ia);
        @(negedge CLK);
        RST = rst; ex_valid = ex; opcode = op; alu_in = alu;
        store_data = sd; halt_in = h; flush = f; dhit = dh;
        dload = dl; inv_valid = iv; inv_addr = ia;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_ll(input logic [31:0] a);
        drive(0, 1, LL, a, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, ADD, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        idle();
    endtask

    initial begin
        //          rst ex op   alu           sd     h f dh dl            iv ia
        //          ren wen daddr   dstore stall men dloadi        alui     hlt lv
        tbl[0]  = mk(1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, ADD, 32'h77, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, ADD, 32'h1234, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
        tbl[3]  = mk(0, 1, LW, 32'h40, 0, 0, 1, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, LW, 32'h1006, 32'h99, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, ADD, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0,
                     1, 0, 32'h1004, 32'h99, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 32'h1004, 32'h99, 0, 1, 32'hDEADBEEF,
                     32'h1004, 0, 0);
        tbl[7]  = mk(0, 0, ADD, 0, 0, 0, 0, 0, 32'h1111, 0, 0,
                     0, 0, 32'h1004, 32'h99, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[8]  = mk(0, 1, SC, 32'h300, 32'h5, 0, 0, 0, 0, 0, 0,
                     0, 0, 32'h1004, 32'h99, 0, 1, 32'hDEADBEEF, 0, 0, 0);
        tbl[9]  = mk(0, 1, SW, 32'h2000, 32'hAB, 0, 0, 0, 0, 0, 0,
                     0, 0, 32'h1004, 32'h99, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[10] = mk(0, 1, ADD, 32'h9, 0, 0, 1, 0, 0, 0, 0,
                     0, 1, 32'h2000, 32'hAB, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[11] = mk(0, 1, ADD, 32'h9, 0, 0, 1, 1, 32'h5555, 0, 0,
                     0, 1, 32'h2000, 32'hAB, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[12] = mk(0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 32'h2000, 32'hAB, 0, 1, 32'hDEADBEEF,
                     32'h2000, 0, 0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].ex, tbl[i].op, tbl[i].alu, tbl[i].sd,
                  tbl[i].h, tbl[i].f, tbl[i].dh, tbl[i].dl, tbl[i].iv,
                  tbl[i].ia);
            chk($sformatf("v%0d.dREN", i), dREN, tbl[i].ren);
            chk($sformatf("v%0d.dWEN", i), dWEN, tbl[i].wen);
            chk($sformatf("v%0d.daddr", i), daddr, tbl[i].daddr);
            chk($sformatf("v%0d.dstore", i), dstore, tbl[i].dstore);
            chk($sformatf("v%0d.mem_stall", i), mem_stall, tbl[i].stall);
            chk($sformatf("v%0d.memory_en", i), memory_en, tbl[i].men);
            chk($sformatf("v%0d.dloadi", i), dloadi, tbl[i].dloadi);
            chk($sformatf("v%0d.alui", i), alui, tbl[i].alui);
            chk($sformatf("v%0d.halt_out", i), halt_out, tbl[i].hlt);
            chk($sformatf("v%0d.link_valid", i), link_valid, tbl[i].lv);
        end

        // SW with dhit arriving on the fourth REQ cycle
        drive(0, 1, SW, 32'h3008, 32'h12345678, 0, 0, 0, 0, 0, 0);
        chk("sw.c1.stall", mem_stall, 1);
        chk("sw.c1.men", memory_en, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, ADD, 0, 0, 0, 0, (k == 3), 0, 0, 0);
            chk($sformatf("sw.req%0d.dWEN", k), dWEN, 1);
            chk($sformatf("sw.req%0d.stall", k), mem_stall, 1);
            chk($sformatf("sw.req%0d.men", k), memory_en, 0);
            chk($sformatf("sw.req%0d.daddr", k), daddr, 32'h3008);
            chk($sformatf("sw.req%0d.dstore", k), dstore, 32'h12345678);
        end
        idle();
        chk("sw.c6.men", memory_en, 1);
        chk("sw.c6.stall", mem_stall, 0);
        chk("sw.c6.dWEN", dWEN, 0);
        chk("sw.c6.alui", alui, 32'h3008);

        // LL 0x200 then passing SC 0x200
        drive(0, 1, LL, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        chk("ll.c1.stall", mem_stall, 1);
        drive(0, 0, ADD, 0, 0, 0, 0, 1, 32'h77, 0, 0);
        chk("ll.c2.dREN", dREN, 1);
        idle();
        chk("ll.done.men", memory_en, 1);
        chk("ll.done.alui", alui, 32'h200);
        chk("ll.done.lv", link_valid, 0);
        drive(0, 1, SC, 32'h200, 32'h55, 0, 0, 0, 0, 0, 0);
        chk("sc.c1.lv", link_valid, 1);
        chk("sc.c1.stall", mem_stall, 1);
        chk("sc.c1.men", memory_en, 0);
        chk("sc.c1.dloadi", dloadi, 32'h77);
        drive(0, 0, ADD, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("sc.req.dWEN", dWEN, 1);
        chk("sc.req.dstore", dstore, 32'h55);
        chk("sc.req.daddr", daddr, 32'h200);
        chk("sc.req.lv", link_valid, 0);
        idle();
        chk("sc.done.men", memory_en, 1);
        chk("sc.done.alui", alui, 32'h1);
        idle();
        chk("sc.after.lv", link_valid, 0);

        // Invalidate between LL and SC
        do_ll(32'h200);
        drive(0, 0, ADD, 0, 0, 0, 0, 0, 0, 1, 32'h203);
        chk("inv.c1.lv", link_valid, 1);
        drive(0, 1, SC, 32'h200, 32'h66, 0, 0, 0, 0, 0, 0);
        chk("inv.sc.lv", link_valid, 0);
        chk("inv.sc.dWEN", dWEN, 0);
        chk("inv.sc.men", memory_en, 1);
        chk("inv.sc.alui", alui, 0);
        chk("inv.sc.stall", mem_stall, 0);
        idle();
        chk("inv.next.dWEN", dWEN, 0);
        chk("inv.next.stall", mem_stall, 0);

        // Invalidate in the same cycle as the SC
        do_ll(32'h400);
        drive(0, 1, SC, 32'h400, 32'h1, 0, 0, 0, 0, 1, 32'h400);
        chk("invsc.lv", link_valid, 1);
        chk("invsc.men", memory_en, 1);
        chk("invsc.alui", alui, 0);
        chk("invsc.stall", mem_stall, 0);
        idle();
        chk("invsc.next.dWEN", dWEN, 0);
        chk("invsc.next.lv", link_valid, 0);

        // Invalidate during the LL DONE cycle wins over the new reservation
        drive(0, 1, LL, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, ADD, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, ADD, 0, 0, 0, 0, 0, 0, 1, 32'h501);
        chk("invll.done.men", memory_en, 1);
        idle();
        chk("invll.lv", link_valid, 0);
        drive(0, 1, SC, 32'h500, 32'h2, 0, 0, 0, 0, 0, 0);
        chk("invll.sc.men", memory_en, 1);
        chk("invll.sc.alui", alui, 0);
        chk("invll.sc.stall", mem_stall, 0);

        // Reset in the second REQ cycle of a LW
        do_ll(32'h600);
        drive(0, 1, LW, 32'h700, 32'h3, 0, 0, 0, 0, 0, 0);
        chk("rst.acc.lv", link_valid, 1);
        drive(0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst.req1.dREN", dREN, 1);
        drive(1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst.req2.dREN", dREN, 1);
        drive(0, 0, ADD, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0);
        chk("rst.dREN", dREN, 0);
        chk("rst.dWEN", dWEN, 0);
        chk("rst.daddr", daddr, 0);
        chk("rst.dstore", dstore, 0);
        chk("rst.stall", mem_stall, 0);
        chk("rst.men", memory_en, 0);
        chk("rst.dloadi", dloadi, 0);
        chk("rst.alui", alui, 0);
        chk("rst.halt", halt_out, 0);
        chk("rst.lv", link_valid, 0);
        drive(0, 1, ADD, 32'h42, 0, 0, 0, 0, 0, 0, 0);
        chk("rst.after.dloadi", dloadi, 0);
        chk("rst.after.men", memory_en, 1);
        chk("rst.after.alui", alui, 32'h42);
        chk("rst.after.stall", mem_stall, 0);

        // ADD then HALT, halt sticks until reset
        drive(0, 1, ADD, 32'h11, 0, 0, 0, 0, 0, 0, 0);
        chk("halt.add.men", memory_en, 1);
        chk("halt.add.alui", alui, 32'h11);
        drive(0, 1, 6'h3F, 32'h22, 0, 1, 0, 0, 0, 0, 0);
        chk("halt.c1.men", memory_en, 1);
        chk("halt.c1.stall", mem_stall, 0);
        chk("halt.c1.halt", halt_out, 0);
        drive(0, 1, LW, 32'h700, 0, 0, 0, 0, 0, 0, 0);
        chk("halt.lw.halt", halt_out, 1);
        chk("halt.lw.stall", mem_stall, 1);
        chk("halt.lw.men", memory_en, 0);
        chk("halt.lw.dREN", dREN, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, LW, 32'h700, 0, 0, 1, 1, 32'h9, 0, 0);
            chk($sformatf("halt.h%0d.dREN", k), dREN, 0);
            chk($sformatf("halt.h%0d.halt", k), halt_out, 1);
            chk($sformatf("halt.h%0d.stall", k), mem_stall, 1);
        end
        drive(1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("halt.rst.halt", halt_out, 0);
        chk("halt.rst.stall", mem_stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
